// File: rtl/sweep_pkg.sv
// Shared types and constants for the sweep scheduler and its step counter.
package sweep_pkg;

   // Scheduler FSM: arbitrate, sweep, one-cycle completion gap.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } state_t;

   // Step index width is fixed; LEN may be anything from 2 to 64.
   localparam int IDX_W       = 6;
   localparam int LEN_DEFAULT = 64;

endpackage

// File: rtl/sweep_step_ctr.sv
// Step counter for one sweep: counts 0..LEN-1 while enabled and wraps to 0
// after the terminal count, so the index is already 0 for the next sweep.
module sweep_step_ctr
   import sweep_pkg::*;
#(
   parameter int LEN = LEN_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [IDX_W-1:0] idx,
   output logic             last
);

   localparam logic [IDX_W-1:0] TC = IDX_W'(LEN - 1);

   assign last = (idx == TC);

   // Advance one step per enabled cycle, wrapping at the terminal count.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values of the others, independent of block order.
      if (rst) begin
         idx <= '0;
      end else if (clr) begin
         idx <= '0;
      end else if (en) begin
         idx <= last ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/sweep_sched.sv
// Round-robin scheduler that hands a single sweep engine to one of NREQ
// requesters at a time. A granted sweep always runs all LEN steps (pause only
// stretches it), then a one-cycle GAP pulses done to the owner before the
// engine returns to IDLE for the next arbitration.
module sweep_sched
   import sweep_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int LEN  = LEN_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req,
   input  logic             pause,
   output logic [NREQ-1:0]  grant,
   output logic             busy,
   output logic             step_valid,
   output logic [IDX_W-1:0] step_idx,
   output logic [NREQ-1:0]  done
);

   localparam int              PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   state_t          state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   owner;
   logic [PW-1:0]   pick_idx;
   logic            pick_found;
   int              cand;
   logic            ctr_en;
   logic            ctr_clr;
   logic            ctr_last;

   // Round-robin pick: first requester at or above ptr, wrapping past NREQ-1.
   always_comb begin
      // NOTE: every combinational output gets a default before the loop so
      // no path leaves it unassigned, which would otherwise infer a latch.
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      for (int i = 0; i < NREQ; i++) begin
         cand = (int'(ptr) + i) % NREQ;
         if (!pick_found && req[cand[PW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[PW-1:0];
         end
      end
   end

   // The counter only moves on issued steps and is held at 0 between sweeps.
   assign ctr_en  = (state == RUN) && step_valid;
   assign ctr_clr = (state == IDLE);

   sweep_step_ctr #(
      .LEN (LEN)
   ) u_step_ctr (
      .clk  (clk),
      .rst  (rst),
      .clr  (ctr_clr),
      .en   (ctr_en),
      .idx  (step_idx),
      .last (ctr_last)
   );

   // Scheduler FSM with registered grant/busy/step_valid/done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= '0;
         owner      <= '0;
         grant      <= '0;
         busy       <= 1'b0;
         step_valid <= 1'b0;
         done       <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= '0;
               busy <= 1'b0;
               // pause is deliberately ignored here: the first step of a
               // new sweep is always issued.
               if (pick_found) begin
                  state      <= RUN;
                  owner      <= pick_idx;
                  grant      <= ONE << pick_idx;
                  busy       <= 1'b1;
                  step_valid <= 1'b1;
               end
            end
            RUN: begin
               if (step_valid && ctr_last) begin
                  state      <= GAP;
                  grant      <= '0;
                  step_valid <= 1'b0;
                  done       <= ONE << owner;
               end else begin
                  step_valid <= ~pause;
               end
            end
            GAP: begin
               state <= IDLE;
               done  <= '0;
               busy  <= 1'b0;
               ptr   <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sweep_sched.sv
// Self-checking bench for sweep_sched: a default-size instance checked every
// cycle against a sweep-level model, plus a LEN=2/NREQ=2 instance checked
// against hand-written expectations.
module tb_sweep_sched;

   localparam int N = 4;
   localparam int L = 64;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       pause;
   logic [3:0] grant;
   logic       busy;
   logic       step_valid;
   logic [5:0] step_idx;
   logic [3:0] done;

   logic [1:0] req_b;
   logic       pause_b;
   logic [1:0] grant_b;
   logic       busy_b;
   logic       step_valid_b;
   logic [5:0] step_idx_b;
   logic [1:0] done_b;

   int checks;
   int errors;

   sweep_sched #(.NREQ(4), .LEN(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .pause      (pause),
      .grant      (grant),
      .busy       (busy),
      .step_valid (step_valid),
      .step_idx   (step_idx),
      .done       (done)
   );

   sweep_sched #(.NREQ(2), .LEN(2)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .req        (req_b),
      .pause      (pause_b),
      .grant      (grant_b),
      .busy       (busy_b),
      .step_valid (step_valid_b),
      .step_idx   (step_idx_b),
      .done       (done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- sweep-level model of the default instance ----------
   // phase: 0 = no owner, 1 = sweeping, 2 = completion cycle
   int m_phase;
   int m_owner;
   int m_pos;
   int m_ptr;
   int m_win;
   bit m_valid;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0;
         m_owner = 0;
         m_pos   = 0;
         m_ptr   = 0;
         m_valid = 0;
      end else begin
         case (m_phase)
            0: begin
               m_win = -1;
               for (int k = 0; k < N; k++) begin
                  automatic int c = (m_ptr + k) % N;
                  if (m_win < 0 && req[c[1:0]]) m_win = c;
               end
               if (m_win >= 0) begin
                  m_phase = 1;
                  m_owner = m_win;
                  m_pos   = 0;
                  m_valid = 1;
               end
            end
            1: begin
               if (m_valid && m_pos == L - 1) begin
                  m_phase = 2;
                  m_pos   = 0;
                  m_valid = 0;
               end else begin
                  if (m_valid) m_pos++;
                  m_valid = !pause;
               end
            end
            default: begin
               m_phase = 0;
               m_ptr   = (m_owner + 1) % N;
            end
         endcase
      end
   end

   // Every cycle: DUT outputs against the model.
   always @(negedge clk) begin
      check("m_grant", 32'(grant), (m_phase == 1) ? (32'd1 << m_owner) : 32'd0);
      check("m_busy", 32'(busy), 32'(m_phase != 0));
      check("m_valid", 32'(step_valid), 32'(m_valid));
      check("m_idx", 32'(step_idx), 32'(m_pos));
      check("m_done", 32'(done), (m_phase == 2) ? (32'd1 << m_owner) : 32'd0);
   end

   // ---------------- helpers ---------------------------------------------
   task automatic wait_grant(output int n);
      n = 0;
      while (grant == 4'b0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("wait_grant_timeout", 32'(grant != 4'b0), 32'd1);
   endtask

   // Called on the first negedge of a sweep; returns on its GAP negedge.
   task automatic run_sweep(input logic [3:0] g, input int pause_at, input int drop_at,
                            input logic [3:0] new_req, output int len);
      int exp_idx;
      int pause_left;
      bit paused;
      len        = 0;
      exp_idx    = 0;
      pause_left = 0;
      paused     = 0;
      while (grant == g && len < 200) begin
         len++;
         if (step_valid) begin
            check("idx_seq", 32'(step_idx), 32'(exp_idx));
            exp_idx++;
         end
         if (pause_left > 0) begin
            check("pause_valid", 32'(step_valid), 32'd0);
            check("pause_idx", 32'(step_idx), 32'(pause_at));
            pause_left--;
            if (pause_left == 0) pause = 1'b0;
         end else if (pause_at >= 0 && !paused && step_valid && step_idx == 6'(pause_at - 1)) begin
            pause      = 1'b1;
            pause_left = 5;
            paused     = 1;
         end
         if (drop_at >= 0 && step_valid && step_idx == 6'(drop_at)) req = new_req;
         @(negedge clk);
      end
      check("issued_steps", 32'(exp_idx), 32'(L));
      check("gap_done", 32'(done), 32'(g));
      check("gap_busy", 32'(busy), 32'd1);
      check("gap_valid", 32'(step_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ------------------------------------
   initial begin
      int n;
      int len;
      logic [3:0] rr_exp [5];
      logic [1:0] b_exp [4];
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      req     = 4'b0;
      pause   = 1'b0;
      req_b   = 2'b0;
      pause_b = 1'b0;
      rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      b_exp   = '{2'b01, 2'b10, 2'b01, 2'b10};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(step_valid), 32'd0);
      check("rst_idx", 32'(step_idx), 32'd0);
      check("rst_done", 32'(done), 32'd0);

      // Single requester from reset: 64 steps, done, then idle
      @(posedge clk); #1;
      rst = 1'b0;
      req = 4'b0001;
      wait_grant(n);
      check("first_arb_latency", 32'(n), 32'd2);
      check("s1_grant", 32'(grant), 32'h1);
      check("s1_idx0", 32'(step_idx), 32'd0);
      check("s1_valid0", 32'(step_valid), 32'd1);
      req = 4'b0;
      run_sweep(4'b0001, -1, -1, 4'b0, len);
      check("s1_len", 32'(len), 32'd64);
      @(negedge clk);
      check("s1_idle_busy", 32'(busy), 32'd0);
      check("s1_idle_done", 32'(done), 32'd0);

      // All requesting: round-robin order with GAP+IDLE between sweeps
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_grant(n);
         if (i > 0) check("rr_gap_cycles", 32'(n), 32'd2);
         check("rr_grant", 32'(grant), 32'(rr_exp[i]));
         if (i == 4) req = 4'b0;
         run_sweep(rr_exp[i], -1, -1, 4'b0, len);
         check("rr_len", 32'(len), 32'd64);
      end

      // Pause for 5 cycles at step 10
      @(negedge clk);
      req = 4'b0010;
      wait_grant(n);
      check("p_grant", 32'(grant), 32'h2);
      req = 4'b0;
      run_sweep(4'b0010, 10, -1, 4'b0, len);
      check("p_len", 32'(len), 32'd69);

      // Pause in IDLE ignored; reset mid-sweep aborts without done
      pause = 1'b1;
      req   = 4'b0100;
      wait_grant(n);
      check("r_grant", 32'(grant), 32'h4);
      check("r_entry_valid", 32'(step_valid), 32'd1);
      pause = 1'b0;
      req   = 4'b0;
      n = 0;
      while (!(step_valid && step_idx == 6'd29) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("r_reach_29", 32'(step_idx), 32'd29);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("r_abort_grant", 32'(grant), 32'd0);
      check("r_abort_busy", 32'(busy), 32'd0);
      check("r_abort_valid", 32'(step_valid), 32'd0);
      check("r_abort_idx", 32'(step_idx), 32'd0);
      check("r_abort_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      req = 4'b0101;
      wait_grant(n);
      check("r_after_grant", 32'(grant), 32'h1);
      req = 4'b0;
      run_sweep(4'b0001, -1, -1, 4'b0, len);
      check("r_after_len", 32'(len), 32'd64);

      // Owner drops at step 5 while req[2] rises
      @(negedge clk);
      req = 4'b0010;
      wait_grant(n);
      check("d_grant", 32'(grant), 32'h2);
      run_sweep(4'b0010, -1, 5, 4'b0100, len);
      check("d_len", 32'(len), 32'd64);
      wait_grant(n);
      check("d_next_gap", 32'(n), 32'd2);
      check("d_next_grant", 32'(grant), 32'h4);
      req = 4'b0;
      run_sweep(4'b0100, -1, -1, 4'b0, len);

      // LEN=2, NREQ=2 instance: idx 0,1 per sweep, alternating grants
      @(posedge clk); #1 req_b = 2'b11;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (grant_b == 2'b0 && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("b_grant", 32'(grant_b), 32'(b_exp[i]));
         check("b_idx0", 32'(step_idx_b), 32'd0);
         check("b_valid0", 32'(step_valid_b), 32'd1);
         if (i == 3) req_b = 2'b0;
         @(negedge clk);
         check("b_grant1", 32'(grant_b), 32'(b_exp[i]));
         check("b_idx1", 32'(step_idx_b), 32'd1);
         check("b_valid1", 32'(step_valid_b), 32'd1);
         @(negedge clk);
         check("b_gap_grant", 32'(grant_b), 32'd0);
         check("b_gap_done", 32'(done_b), 32'(b_exp[i]));
         check("b_gap_busy", 32'(busy_b), 32'd1);
         check("b_gap_idx", 32'(step_idx_b), 32'd0);
         @(negedge clk);
         check("b_idle_busy", 32'(busy_b), 32'd0);
         check("b_idle_done", 32'(done_b), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sweep_sched.md
SWEEP_SCHED -- requirements
Module: sweep_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the sweep engine (2..8).
REQ-002 Parameter LEN, default 64, steps per sweep (2..64); index width is fixed at 6 bits.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  NREQ  per-requester sweep request, level-sensitive.
REQ-006 pause  input  1  freezes the active sweep while high.
REQ-007 grant  output  NREQ  one-hot owner of the sweep engine, all-zero when idle.
REQ-008 busy  output  1  high while a sweep is owned, i.e. state RUN or GAP.
REQ-009 step_valid  output  1  high on every cycle a step index is issued.
REQ-010 step_idx  output  6  current step index, 0..LEN-1.
REQ-011 done  output  NREQ  one-cycle completion pulse to the owning requester.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and GAP.
REQ-013 In IDLE with any req bit high, the block SHALL pick a winner round-robin, searching upward from pointer ptr with wrap at NREQ-1->0, and enter RUN on the next edge.
REQ-014 On entry to RUN, grant SHALL be one-hot for the winner and step_idx SHALL be 0.
REQ-015 In RUN with pause low: step_valid=1, and step_idx SHALL increment by 1 per cycle.
REQ-016 In RUN with pause high: step_valid=0, and step_idx and grant SHALL hold.
REQ-017 When step_idx==LEN-1 with step_valid=1, the next state SHALL be GAP, and step_idx SHALL wrap to 0.
REQ-018 In GAP (exactly one cycle): grant=0, step_valid=0, busy=1, done[winner]=1, ptr<=winner+1 mod NREQ; next state IDLE.
REQ-019 Arbitration occurs only in IDLE, so back-to-back sweeps SHALL be separated by exactly two cycles: GAP then IDLE.
REQ-020 Once granted, a sweep SHALL run to completion even if req of the owner drops; new requests during RUN SHALL wait.
REQ-021 A requester whose req is still high after done SHALL be treated as a new request, subject to round-robin.
REQ-022 pause asserted in IDLE or GAP SHALL have no effect.
REQ-023 Exactly one sweep completion SHALL pulse done per grant; done bits are never multi-hot.

Reset
REQ-024 While rst is high: state=IDLE, ptr=0, grant=0, busy=0, step_valid=0, step_idx=0, done=0.
REQ-025 rst asserted mid-sweep SHALL abort the sweep without any done pulse; arbitration resumes from ptr=0 after release.
REQ-026 The first arbitration after reset SHALL occur on the first posedge with rst low.

Structure
REQ-027 Shared package sweep_pkg SHALL hold the state enum (IDLE, RUN, GAP), the constant IDX_W=6 and the default LEN=64.
REQ-028 The step counter SHALL be a sub-module sweep_step_ctr with inputs clk, rst, clr, en and terminal count LEN-1, and outputs idx[5:0] and last.
REQ-029 The round-robin pick SHALL be combinational logic in sweep_sched; all outputs SHALL be registered.

Verification
REQ-030 req=0001 from reset -> grant=0001 for 64 cycles, step_idx 0..63, done=0001 one cycle later, then busy=0.
REQ-031 req=1111 held -> grants in order 0001,0010,0100,1000,0001, with 2 idle cycles between sweeps.
REQ-032 pause high for 5 cycles at step_idx=10 -> step_valid=0, idx holds 10 for those cycles, and the sweep lasts 69 cycles.
REQ-033 rst pulse at step_idx=30 of grant 0100 -> all outputs 0, no done pulse, and next req=0101 grants 0001.
REQ-034 The owner drops req at step 5 while req[2] rises -> the sweep finishes to 63, done to the owner, then grant=0100.
REQ-035 LEN=2, NREQ=2, req=11 -> each sweep issues idx 0,1 only, and grants alternate 01,10.
